reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL have the parameter REG_CNT, default 16, meaning number of registers; address width is fixed at 4 bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port wrEN, input, 1 bit: write-back enable from the write-back mux stage.
REQ-006 The block SHALL have port wrAddr, input, 4 bits: write-back destination register.
REQ-007 The block SHALL have port wrData, input, DATA_W bits: write-back data, either ALU result or RAM data as selected upstream.
REQ-008 The block SHALL have ports rdAddrA and rdAddrB, input, 4 bits each: read-port source registers.
REQ-009 The block SHALL have ports rdDataA and rdDataB, output, DATA_W bits each: registered read data.
REQ-010 The block SHALL have port ldIssue, input, 1 bit: an LDR targeting ldAddr is issued this cycle.
REQ-011 The block SHALL have port ldAddr, input, 4 bits: LDR destination register.
REQ-012 The block SHALL have port pendMask, output, REG_CNT bits: registered per-register load-pending flags.
REQ-013 The block SHALL have port stall, output, 1 bit: combinational read-hazard indication.

Function
REQ-014 The block SHALL write reg[wrAddr] <= wrData at each rising edge where wrEN=1; all registers are writable, with no hardwired-zero register.
REQ-015 The block SHALL return read data with 1-cycle latency: at each rising edge where stall=0, rdDataA <= reg[rdAddrA] and rdDataB <= reg[rdAddrB].
REQ-016 The block SHALL bypass write data to reads: when wrEN=1 and wrAddr equals a read address in the same cycle, that port captures wrData, not the stale register value.
REQ-017 The block SHALL capture identically on both ports when rdAddrA=rdAddrB, including bypass.
REQ-018 The block SHALL set pendMask[ldAddr] at each rising edge where ldIssue=1.
REQ-019 The block SHALL clear pendMask[wrAddr] at each rising edge where wrEN=1.
REQ-020 The block SHALL give set priority when ldIssue=1 and wrEN=1 with ldAddr=wrAddr in the same cycle: the bit ends at 1 (the new load remains outstanding); the write itself still occurs.
REQ-021 The block SHALL leave pendMask[ldAddr] at 1 on an ldIssue to an already-pending register; no counting, no error.
REQ-022 The block SHALL drive stall = hazA | hazB, where hazX = pendMask[rdAddrX] & ~(wrEN & wrAddr==rdAddrX); a write-back arriving in the same cycle resolves the hazard through the bypass.
REQ-023 The block SHALL NOT consider ldIssue in the current cycle when computing stall; only registered pendMask counts.
REQ-024 The block SHALL hold both rdDataA and rdDataB at their previous values while stall=1; register writes and pendMask updates proceed normally.
REQ-025 The block SHALL ignore wrAddr, ldAddr and wrData when their enables are 0.

Reset
REQ-026 The block SHALL, while rst=1, immediately and asynchronously force all registers, rdDataA, rdDataB and pendMask to 0; stall is therefore 0.
REQ-027 The block SHALL discard any write or ldIssue coincident with reset assertion; pending loads across reset are lost.
REQ-028 The block SHALL perform its first update at the first rising edge after rst deasserts.

Verification
REQ-029 The bench SHALL cover basic write/read: wrEN=1, wrAddr=3, wrData=0x12345678; next cycle rdAddrA=3 -> rdDataA=0x12345678 one edge later.
REQ-030 The bench SHALL cover bypass: reg5=0x1; same cycle wrEN=1, wrAddr=5, wrData=0xDEADBEEF, rdAddrB=5 -> rdDataB=0xDEADBEEF after that edge.
REQ-031 The bench SHALL cover load hazard: ldIssue=1, ldAddr=7; next cycle rdAddrA=7, wrEN=0 -> pendMask=0x0080, stall=1, rdDataA held; then wrEN=1, wrAddr=7, wrData=0xA5A5A5A5 -> stall=0 that cycle, rdDataA=0xA5A5A5A5, pendMask=0x0000.
REQ-032 The bench SHALL cover simultaneous set/clear: pendMask[2]=1; ldIssue=1, ldAddr=2 with wrEN=1, wrAddr=2, wrData=0x55 -> pendMask[2]=1, reg2=0x55.
REQ-033 The bench SHALL cover reset mid-operation: pendMask=0x8001, regs nonzero, assert rst between edges -> pendMask, rdDataA, rdDataB=0 and stall=0 without a clock edge; reads after release return 0.
REQ-034 The bench SHALL cover same-address dual read: rdAddrA=rdAddrB=9 with reg9=0xCAFEF00D -> both outputs 0xCAFEF00D.

Source files
------------

// File: rtl/reg_bank_if.sv
// Register bank bus: write-back, two read ports, load tracking and hazard status.
interface reg_bank_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 16
);
    localparam int unsigned ADDR_W = 4;

    logic                wrEN;
    logic [ADDR_W-1:0]   wrAddr;
    logic [DATA_W-1:0]   wrData;
    logic [ADDR_W-1:0]   rdAddrA;
    logic [ADDR_W-1:0]   rdAddrB;
    logic [DATA_W-1:0]   rdDataA;
    logic [DATA_W-1:0]   rdDataB;
    logic                ldIssue;
    logic [ADDR_W-1:0]   ldAddr;
    logic [REG_CNT-1:0]  pendMask;
    logic                stall;

    modport master (
        output wrEN, wrAddr, wrData, rdAddrA, rdAddrB, ldIssue, ldAddr,
        input  rdDataA, rdDataB, pendMask, stall
    );

    modport slave (
        input  wrEN, wrAddr, wrData, rdAddrA, rdAddrB, ldIssue, ldAddr,
        output rdDataA, rdDataB, pendMask, stall
    );
endinterface

// File: rtl/reg_bank.sv
// Register file with write-back bypass, registered dual read ports and
// per-register load-pending scoreboard that stalls reads of in-flight loads.
module reg_bank #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);
    logic [DATA_W-1:0]  regs [REG_CNT];
    logic [DATA_W-1:0]  rd_a_next;
    logic [DATA_W-1:0]  rd_b_next;
    logic [REG_CNT-1:0] pend_next;
    logic               byp_a;
    logic               byp_b;
    logic               haz_a;
    logic               haz_b;

    // Bypass detection, hazard evaluation and read-data selection
    always_comb begin
        byp_a     = bus.wrEN && (bus.wrAddr == bus.rdAddrA);
        byp_b     = bus.wrEN && (bus.wrAddr == bus.rdAddrB);
        // A same-cycle write-back satisfies the pending load through the bypass
        haz_a     = bus.pendMask[bus.rdAddrA] && !byp_a;
        haz_b     = bus.pendMask[bus.rdAddrB] && !byp_b;
        rd_a_next = byp_a ? bus.wrData : regs[bus.rdAddrA];
        rd_b_next = byp_b ? bus.wrData : regs[bus.rdAddrB];
    end

    assign bus.stall = haz_a | haz_b;

    // Pending-load update: write-back clears, new load sets (set wins on a tie)
    always_comb begin
        pend_next = bus.pendMask;
        if (bus.wrEN) begin
            pend_next[bus.wrAddr] = 1'b0;
        end
        if (bus.ldIssue) begin
            pend_next[bus.ldAddr] = 1'b1;
        end
    end

    // Register array write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wrEN) begin
            regs[bus.wrAddr] <= bus.wrData;
        end
    end

    // Read-port capture, held while a hazard is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdDataA <= '0;
            bus.rdDataB <= '0;
        end else if (!bus.stall) begin
            bus.rdDataA <= rd_a_next;
            bus.rdDataB <= rd_b_next;
        end
    end

    // Load-pending scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pendMask <= '0;
        end else begin
            bus.pendMask <= pend_next;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus random traffic
// compared against an array-based behavioural model.
module tb_reg_bank;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_CNT = 16;

    logic clk;
    logic rst;

    reg_bank_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) bus ();

    reg_bank #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Behavioural model state
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    logic [31:0] m_rda;
    logic [31:0] m_rdb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_pend = '0;
        m_rda  = '0;
        m_rdb  = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rdDataA"},  64'(bus.rdDataA),  64'(m_rda));
        check({tag, ".rdDataB"},  64'(bus.rdDataB),  64'(m_rdb));
        check({tag, ".pendMask"}, 64'(bus.pendMask), 64'(m_pend));
    endtask

    // One clock cycle of stimulus: drive at negedge, check stall before the
    // edge, update the model at the edge, check registered outputs after it.
    task automatic step(input string tag,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic ld, input logic [3:0] la,
                        input logic [3:0] ra, input logic [3:0] rb);
        logic exp_stall;
        logic [31:0] val_a;
        logic [31:0] val_b;
        @(negedge clk);
        bus.wrEN    = we;
        bus.wrAddr  = wa;
        bus.wrData  = wd;
        bus.ldIssue = ld;
        bus.ldAddr  = la;
        bus.rdAddrA = ra;
        bus.rdAddrB = rb;
        #1;
        // A read stalls if its source awaits a load not delivered this cycle
        exp_stall = (m_pend[ra] && !(we && wa == ra)) || (m_pend[rb] && !(we && wa == rb));
        check({tag, ".stall"}, 64'(bus.stall), 64'(exp_stall));
        @(posedge clk);
        val_a = (we && wa == ra) ? wd : m_regs[ra];
        val_b = (we && wa == rb) ? wd : m_regs[rb];
        if (!exp_stall) begin
            m_rda = val_a;
            m_rdb = val_b;
        end
        if (we) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
        end
        if (ld) m_pend[la] = 1'b1;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        bus.wrEN    = 1'b0;
        bus.wrAddr  = '0;
        bus.wrData  = '0;
        bus.ldIssue = 1'b0;
        bus.ldAddr  = '0;
        bus.rdAddrA = '0;
        bus.rdAddrB = '0;
        model_reset();
        rst = 1'b1;
        #12;
        check_outputs("reset");
        check("reset.stall", 64'(bus.stall), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read
        step("wr3",  1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 4'd0, 4'd0);
        step("rd3",  1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 4'd3, 4'd0);
        check("rd3.value", 64'(bus.rdDataA), 64'(32'h1234_5678));

        // Write-back bypass on port B
        step("wr5",  1'b1, 4'd5, 32'h1,         1'b0, 4'd0, 4'd0, 4'd0);
        step("byp5", 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0, 4'd5);
        check("byp5.value", 64'(bus.rdDataB), 64'(32'hDEAD_BEEF));

        // Load hazard: issue, stall, resolve via same-cycle write-back
        step("ld7",   1'b0, 4'd0, 32'h0,         1'b1, 4'd7, 4'd3, 4'd0);
        step("haz7",  1'b0, 4'd0, 32'h0,         1'b0, 4'd0, 4'd7, 4'd0);
        check("haz7.pend", 64'(bus.pendMask), 64'(16'h0080));
        check("haz7.held", 64'(bus.rdDataA), 64'(32'h1234_5678));
        step("res7",  1'b1, 4'd7, 32'hA5A5_A5A5, 1'b0, 4'd0, 4'd7, 4'd0);
        check("res7.value", 64'(bus.rdDataA), 64'(32'hA5A5_A5A5));
        check("res7.pend",  64'(bus.pendMask), 64'(16'h0000));

        // Simultaneous set and clear on register 2
        step("ld2",  1'b0, 4'd0, 32'h0,  1'b1, 4'd2, 4'd0, 4'd0);
        step("sc2",  1'b1, 4'd2, 32'h55, 1'b1, 4'd2, 4'd0, 4'd0);
        check("sc2.pendbit", 64'(bus.pendMask[2]), 64'(1));
        step("clr2", 1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 4'd0, 4'd0);
        step("rd2",  1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 4'd2, 4'd2);
        check("rd2.value", 64'(bus.rdDataA), 64'(32'h55));

        // Same-address dual read
        step("wr9",  1'b1, 4'd9, 32'hCAFE_F00D, 1'b0, 4'd0, 4'd0, 4'd0);
        step("dual9", 1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd9, 4'd9);
        check("dual9.a", 64'(bus.rdDataA), 64'(32'hCAFE_F00D));
        check("dual9.b", 64'(bus.rdDataB), 64'(32'hCAFE_F00D));

        // Reset mid-operation, asserted between edges with a write pending
        step("ld0",  1'b0, 4'd0, 32'h0, 1'b1, 4'd0,  4'd9, 4'd3);
        step("ld15", 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd9, 4'd3);
        check("ld15.pend", 64'(bus.pendMask), 64'(16'h8001));
        @(negedge clk);
        bus.wrEN    = 1'b1;
        bus.wrAddr  = 4'd4;
        bus.wrData  = 32'h7777_7777;
        bus.ldIssue = 1'b1;
        bus.ldAddr  = 4'd6;
        bus.rdAddrA = 4'd0;
        bus.rdAddrB = 4'd15;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rstmid");
        check("rstmid.stall", 64'(bus.stall), 64'(0));
        @(negedge clk);
        bus.wrEN    = 1'b0;
        bus.ldIssue = 1'b0;
        rst = 1'b0;
        step("post3", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd9);
        step("post4", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd5);
        check("post.zero", 64'(bus.rdDataA), 64'(0));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
